// File: rtl/word_uart_transmitter.sv
// Sends a 32-bit word as four 8N1 UART bytes, MSB byte first, with its own baud divider.
// Optional WORD_TX_CHECKSUM_EN appends a fifth byte holding the XOR of the four data bytes.
module word_uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        send,
  input  logic [31:0] data_in_32,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef WORD_TX_CHECKSUM_EN
  localparam int unsigned NumBytes = 5;
`else
  localparam int unsigned NumBytes = 4;
`endif

  localparam int unsigned ShW = 8 * NumBytes;
  localparam logic [2:0] LastByte = 3'(NumBytes - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [ShW-1:0]  shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            baud_tick;
  logic [2:0]      next_bit;
  logic [7:0]      cur_byte;
  logic [ShW-1:0]  capture;

`ifdef WORD_TX_CHECKSUM_EN
  assign capture = {data_in_32,
                    data_in_32[31:24] ^ data_in_32[23:16] ^ data_in_32[15:8] ^ data_in_32[7:0]};
`else
  assign capture = data_in_32;
`endif

  // The byte on the wire always sits in the top of the shift register.
  assign cur_byte  = shreg_q[ShW-1 -: 8];
  assign baud_tick = (baud_q == CntMax);
  assign next_bit  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_tick ? '0 : baud_q + CntW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (send && !busy_q) begin
          shreg_d = capture;
          byte_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_tick) begin
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = StData;
        end
      end

      StData: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d = next_bit;
            tx_d  = cur_byte[next_bit];
          end
        end
      end

      StStop: begin
        if (baud_tick) begin
          if (byte_q == LastByte) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            // Next start bit follows the stop bit with no gap.
            byte_d  = byte_q + 3'd1;
            shreg_d = shreg_q << 8;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = StStart;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
